// File: rtl/ysyx_22041461_mem_arbiter.sv
// Two-master, one-slave memory arbiter: I-side refill reads and D-side
// loads/stores share one memory port, one transaction at a time.
module ysyx_22041461_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    output logic              i_resp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wen,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [7:0]        d_req_wmask,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_rdata,
    output logic              d_resp_err,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic              m_req_wen,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [7:0]        m_req_wmask,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_rdata,
    input  logic              m_resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [7:0]        timer_q, timer_d;
    logic              i_pulse_q, i_pulse_d;
    logic              d_pulse_q, d_pulse_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic idle;
    logic grant_i;
    logic grant_d;
    logic accept;
    logic done;
    logic expire;

    // last_q/owner_q: 1 = D side, 0 = I side
    always_comb begin
        idle    = (state_q == IDLE) && rst;
        grant_i = i_req_valid && (!d_req_valid || last_q);
        grant_d = d_req_valid && !grant_i;
        accept  = idle && (i_req_valid || d_req_valid);
        done    = (state_q == RESP) && m_resp_valid;
        expire  = (state_q != IDLE) && (timer_q == TO_LAST) && !done;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            timer_q   <= '0;
            i_pulse_q <= 1'b0;
            d_pulse_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            timer_q   <= timer_d;
            i_pulse_q <= i_pulse_d;
            d_pulse_q <= d_pulse_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (expire) state_d = IDLE;
                else if (m_req_ready) state_d = RESP;
            end
            RESP: if (done || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        timer_d = timer_q;
        if (accept) begin
            last_d  = grant_d;
            owner_d = grant_d;
            timer_d = '0;
            if (grant_d) begin
                addr_d  = d_req_addr;
                wen_d   = d_req_wen;
                wdata_d = d_req_wdata;
                wmask_d = d_req_wmask;
            end else begin
                // refill reads are always a full aligned beat
                addr_d  = i_req_addr & ~ADDR_W'('h7);
                wen_d   = 1'b0;
                wdata_d = '0;
                wmask_d = '0;
            end
        end else if (state_q != IDLE) begin
            timer_d = timer_q + 8'd1;
        end
        i_pulse_d = (done || expire) && !owner_q;
        d_pulse_d = (done || expire) && owner_q;
        rdata_d   = '0;
        if (done && !(owner_q && wen_q)) rdata_d = m_resp_rdata;
        err_d = expire || (done && m_resp_err);
    end

    always_comb begin
        i_req_ready  = idle && grant_i;
        d_req_ready  = idle && grant_d;
        m_req_valid  = (state_q == REQ);
        m_req_addr   = m_req_valid ? addr_q : '0;
        m_req_wen    = m_req_valid && wen_q;
        m_req_wdata  = m_req_valid ? wdata_q : '0;
        m_req_wmask  = m_req_valid ? wmask_q : '0;
        i_resp_valid = i_pulse_q;
        i_resp_data  = i_pulse_q ? rdata_q : '0;
        i_resp_err   = i_pulse_q && err_q;
        d_resp_valid = d_pulse_q;
        d_resp_rdata = d_pulse_q ? rdata_q : '0;
        d_resp_err   = d_pulse_q && err_q;
    end

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
// Directed bench for the memory arbiter, built with an 8-cycle timeout
// so the abort path is reachable quickly.
module tb_ysyx_22041461_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready;
    logic [63:0] i_req_addr;
    logic        i_resp_valid;
    logic [63:0] i_resp_data;
    logic        i_resp_err;
    logic        d_req_valid, d_req_ready;
    logic [63:0] d_req_addr;
    logic        d_req_wen;
    logic [63:0] d_req_wdata;
    logic [7:0]  d_req_wmask;
    logic        d_resp_valid;
    logic [63:0] d_resp_rdata;
    logic        d_resp_err;
    logic        m_req_valid, m_req_ready;
    logic [63:0] m_req_addr;
    logic        m_req_wen;
    logic [63:0] m_req_wdata;
    logic [7:0]  m_req_wmask;
    logic        m_resp_valid;
    logic [63:0] m_resp_rdata;
    logic        m_resp_err;

    int tests = 0;
    int fails = 0;

    ysyx_22041461_mem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_req_addr(i_req_addr), .i_resp_valid(i_resp_valid),
        .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_wen(d_req_wen),
        .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .d_resp_err(d_resp_err),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
        .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
        .m_resp_err(m_resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [9:0] flags;
        rst = 1'b0;
        tick();
        tick();
        flags = {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid,
                 m_req_valid, m_req_wen, i_resp_err, d_resp_err,
                 |m_req_addr, |m_req_wmask};
        tests++;
        if (flags !== 10'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0", flags);
        end
        tests++;
        if ({i_resp_data, d_resp_rdata, m_req_wdata} !== 192'd0) begin
            fails++;
            $display("FAIL reset_data: got nonzero want 0");
        end
        rst = 1'b1;
        tick();
        tests++;
        if (m_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b want 0", m_req_valid);
        end
    endtask

    task automatic test_i_read;
        i_req_valid = 1'b1;
        i_req_addr  = 64'h8000_0004;
        #1;
        tests++;
        if ({i_req_ready, d_req_ready} !== 2'b10) begin
            fails++;
            $display("FAIL iread_ready: got %b want 10",
                     {i_req_ready, d_req_ready});
        end
        tick();
        i_req_valid = 1'b0;
        m_req_ready = 1'b1;
        tests++;
        if ({m_req_valid, m_req_wen, m_req_wmask} !== 10'b1_0_00000000) begin
            fails++;
            $display("FAIL iread_mreq: got %b want 1000000000",
                     {m_req_valid, m_req_wen, m_req_wmask});
        end
        tests++;
        if (m_req_addr !== 64'h8000_0000) begin
            fails++;
            $display("FAIL iread_addr: got %h want 80000000", m_req_addr);
        end
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'h0000_0013_0000_0093;
        tests++;
        if ({m_req_valid, i_resp_valid} !== 2'b00) begin
            fails++;
            $display("FAIL iread_resp_wait: got %b want 00",
                     {m_req_valid, i_resp_valid});
        end
        tick();
        m_resp_valid = 1'b0;
        tests++;
        if ({i_resp_valid, i_resp_err, d_resp_valid} !== 3'b100) begin
            fails++;
            $display("FAIL iread_pulse: got %b want 100",
                     {i_resp_valid, i_resp_err, d_resp_valid});
        end
        tests++;
        if (i_resp_data !== 64'h0000_0013_0000_0093) begin
            fails++;
            $display("FAIL iread_data: got %h want 0000001300000093",
                     i_resp_data);
        end
        tick();
        tests++;
        if ({i_resp_valid, |i_resp_data} !== 2'b00) begin
            fails++;
            $display("FAIL iread_pulse_end: got %b want 00",
                     {i_resp_valid, |i_resp_data});
        end
    endtask

    task automatic test_d_write;
        d_req_valid = 1'b1;
        d_req_addr  = 64'h8000_0100;
        d_req_wen   = 1'b1;
        d_req_wdata = 64'hDEAD_BEEF;
        d_req_wmask = 8'h0F;
        #1;
        tests++;
        if ({i_req_ready, d_req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL dwr_ready: got %b want 01",
                     {i_req_ready, d_req_ready});
        end
        tick();
        d_req_valid = 1'b0;
        m_req_ready = 1'b1;
        tests++;
        if ({m_req_valid, m_req_wen, m_req_wmask} !== 10'b1_1_00001111) begin
            fails++;
            $display("FAIL dwr_ctl: got %b want 1100001111",
                     {m_req_valid, m_req_wen, m_req_wmask});
        end
        tests++;
        if ({m_req_addr, m_req_wdata} !== {64'h8000_0100, 64'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL dwr_fields: got %h %h want 80000100 deadbeef",
                     m_req_addr, m_req_wdata);
        end
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'h1234;
        tick();
        m_resp_valid = 1'b0;
        tests++;
        if ({d_resp_valid, d_resp_err, i_resp_valid} !== 3'b100) begin
            fails++;
            $display("FAIL dwr_pulse: got %b want 100",
                     {d_resp_valid, d_resp_err, i_resp_valid});
        end
        tests++;
        if (d_resp_rdata !== 64'd0) begin
            fails++;
            $display("FAIL dwr_rdata: got %h want 0", d_resp_rdata);
        end
        d_req_wen = 1'b0;
    endtask

    task automatic test_round_robin;
        logic exp_d;
        i_req_addr  = 64'h1000;
        d_req_addr  = 64'h2000;
        d_req_wen   = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2) == 1;
            #1;
            tests++;
            if ({i_req_ready, d_req_ready} !== {!exp_d, exp_d}) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b want %b", k,
                         {i_req_ready, d_req_ready}, {!exp_d, exp_d});
            end
            tick();
            m_req_ready = 1'b1;
            tests++;
            if (m_req_addr !== (exp_d ? 64'h2000 : 64'h1000)) begin
                fails++;
                $display("FAIL rr_addr%0d: got %h", k, m_req_addr);
            end
            tests++;
            if (i_req_ready || d_req_ready) begin
                fails++;
                $display("FAIL rr_busy_ready%0d: got %b want 00", k,
                         {i_req_ready, d_req_ready});
            end
            tick();
            m_req_ready  = 1'b0;
            m_resp_valid = 1'b1;
            m_resp_rdata = 64'h100 + 64'(k);
            tick();
            m_resp_valid = 1'b0;
            if (k == 3) begin
                i_req_valid = 1'b0;
                d_req_valid = 1'b0;
            end
            tests++;
            if ({i_resp_valid, d_resp_valid} !== {!exp_d, exp_d}) begin
                fails++;
                $display("FAIL rr_resp%0d: got %b want %b", k,
                         {i_resp_valid, d_resp_valid}, {!exp_d, exp_d});
            end
        end
    endtask

    task automatic test_timeout;
        i_req_valid = 1'b1;
        i_req_addr  = 64'h4000;
        #1;
        tests++;
        if (i_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL to_ready: got %b want 1", i_req_ready);
        end
        tick();
        i_req_valid = 1'b0;
        m_req_ready = 1'b1;
        tests++;
        if (i_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL to_early1: got %b want 0", i_resp_valid);
        end
        tick();
        m_req_ready = 1'b0;
        for (int off = 2; off <= 8; off++) begin
            tests++;
            if (i_resp_valid !== 1'b0) begin
                fails++;
                $display("FAIL to_early%0d: got %b want 0", off, i_resp_valid);
            end
            tick();
        end
        tests++;
        if ({i_resp_valid, i_resp_err, m_req_valid} !== 3'b110) begin
            fails++;
            $display("FAIL to_pulse: got %b want 110",
                     {i_resp_valid, i_resp_err, m_req_valid});
        end
        tests++;
        if (i_resp_data !== 64'd0) begin
            fails++;
            $display("FAIL to_data: got %h want 0", i_resp_data);
        end
        d_req_valid = 1'b1;
        d_req_addr  = 64'h5000;
        #1;
        tests++;
        if (d_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL to_next_ready: got %b want 1", d_req_ready);
        end
        tick();
        d_req_valid = 1'b0;
        m_req_ready = 1'b1;
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'hCAFE;
        m_resp_err   = 1'b1;
        tick();
        m_resp_valid = 1'b0;
        m_resp_err   = 1'b0;
        tests++;
        if ({d_resp_valid, d_resp_err, d_resp_rdata} !== {2'b11, 64'hCAFE}) begin
            fails++;
            $display("FAIL to_next_resp: got %b%b %h want 11 cafe",
                     d_resp_valid, d_resp_err, d_resp_rdata);
        end
    endtask

    task automatic test_stall;
        d_req_valid = 1'b1;
        d_req_addr  = 64'h3008;
        d_req_wen   = 1'b0;
        d_req_wdata = 64'h55;
        d_req_wmask = 8'hF0;
        #1;
        tests++;
        if (d_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL st_ready: got %b want 1", d_req_ready);
        end
        tick();
        d_req_valid = 1'b0;
        d_req_addr  = 64'hFFFF;
        d_req_wdata = 64'h0;
        m_req_ready = 1'b0;
        for (int off = 1; off <= 5; off++) begin
            m_resp_valid = (off == 3);
            tests++;
            if ({m_req_valid, m_req_addr, m_req_wdata, m_req_wmask, d_resp_valid}
                !== {1'b1, 64'h3008, 64'h55, 8'hF0, 1'b0}) begin
                fails++;
                $display("FAIL st_hold%0d: got %b %h %h %h %b", off,
                         m_req_valid, m_req_addr, m_req_wdata,
                         m_req_wmask, d_resp_valid);
            end
            tick();
        end
        m_resp_valid = 1'b0;
        m_req_ready  = 1'b1;
        tests++;
        if ({m_req_valid, d_resp_valid} !== 2'b10) begin
            fails++;
            $display("FAIL st_spurious: got %b want 10",
                     {m_req_valid, d_resp_valid});
        end
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'h77;
        tick();
        m_resp_valid = 1'b0;
        tests++;
        if ({d_resp_valid, d_resp_err, d_resp_rdata} !== {2'b10, 64'h77}) begin
            fails++;
            $display("FAIL st_resp: got %b%b %h want 10 77",
                     d_resp_valid, d_resp_err, d_resp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        i_req_valid = 1'b1;
        i_req_addr  = 64'h6000;
        tick();
        m_req_ready = 1'b1;
        tick();
        m_req_ready  = 1'b0;
        rst          = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'hBAD;
        #1;
        tests++;
        if ({m_req_valid, i_req_ready, d_req_ready, i_resp_valid,
             d_resp_valid, |m_req_addr} !== 6'd0) begin
            fails++;
            $display("FAIL rm_outputs: got %b want 000000",
                     {m_req_valid, i_req_ready, d_req_ready, i_resp_valid,
                      d_resp_valid, |m_req_addr});
        end
        tick();
        rst          = 1'b1;
        m_resp_valid = 1'b0;
        #1;
        tests++;
        if ({i_req_ready, i_resp_valid} !== 2'b10) begin
            fails++;
            $display("FAIL rm_reaccept: got %b want 10",
                     {i_req_ready, i_resp_valid});
        end
        tick();
        i_req_valid = 1'b0;
        m_req_ready = 1'b1;
        tests++;
        if ({i_resp_valid, m_req_addr} !== {1'b0, 64'h6000}) begin
            fails++;
            $display("FAIL rm_req: got %b %h want 0 6000",
                     i_resp_valid, m_req_addr);
        end
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'h600D;
        tests++;
        if (i_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rm_stale: got %b want 0", i_resp_valid);
        end
        tick();
        m_resp_valid = 1'b0;
        tests++;
        if ({i_resp_valid, i_resp_data} !== {1'b1, 64'h600D}) begin
            fails++;
            $display("FAIL rm_resp: got %b %h want 1 600d",
                     i_resp_valid, i_resp_data);
        end
    endtask

    initial begin
        rst          = 1'b0;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        d_req_valid  = 1'b0;
        d_req_addr   = '0;
        d_req_wen    = 1'b0;
        d_req_wdata  = '0;
        d_req_wmask  = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
        m_resp_err   = 1'b0;
        test_reset();
        test_i_read();
        test_d_write();
        test_round_robin();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
